// File: rtl/ssds_pkg.sv
// ---------------------------------------------------------------------------
// ssds_pkg
//   Shared types and pin-polarity helpers for the seven-segment scan
//   controller.
//   - ssds_state_e : scan FSM state encoding (BLANK, SHOW)
//   - SEG_BLANK    : "nothing lit" segment pattern in lit-form (1 = lit)
//   - seg_on/off   : convert a lit-form segment pattern to pin levels
//   - pin_on       : convert a single lit-form bit (dp, anode) to a pin level
// ---------------------------------------------------------------------------
package ssds_pkg;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } ssds_state_e;

    // Segment order everywhere is {g,f,e,d,c,b,a}, 1 = segment lit.
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] seg_on(input logic [6:0] lit, input logic active_low);
        return active_low ? ~lit : lit;
    endfunction

    function automatic logic [6:0] seg_off(input logic active_low);
        return seg_on(SEG_BLANK, active_low);
    endfunction

    function automatic logic pin_on(input logic lit, input logic active_low);
        return lit ^ active_low;
    endfunction

endpackage

// File: rtl/ssds_digit_mapper.sv
// ---------------------------------------------------------------------------
// ssds_digit_mapper
//   Combinational hex-to-seven-segment decoder. Output is lit-form
//   (1 = segment on); pin polarity is applied by the caller.
//   Ports:
//     i_nibble [3:0] : hex digit 0..F
//     o_seg    [6:0] : segments {g,f,e,d,c,b,a}, 1 = lit
// ---------------------------------------------------------------------------
module ssds_digit_mapper (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'h00;
        case (i_nibble)
            4'h0: o_seg = 7'h3F;
            4'h1: o_seg = 7'h06;
            4'h2: o_seg = 7'h5B;
            4'h3: o_seg = 7'h4F;
            4'h4: o_seg = 7'h66;
            4'h5: o_seg = 7'h6D;
            4'h6: o_seg = 7'h7D;
            4'h7: o_seg = 7'h07;
            4'h8: o_seg = 7'h7F;
            4'h9: o_seg = 7'h6F;
            4'hA: o_seg = 7'h77;
            4'hB: o_seg = 7'h7C;   // lower-case b
            4'hC: o_seg = 7'h39;
            4'hD: o_seg = 7'h5E;   // lower-case d
            4'hE: o_seg = 7'h79;
            4'hF: o_seg = 7'h71;
            default: o_seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/ssds_scan_controller.sv
// ---------------------------------------------------------------------------
// ssds_scan_controller
//   Time-multiplexes DIGITS seven-segment digits onto one shared segment
//   bus. Each digit slot is BLANK_CYCLES of all-dark followed by
//   DWELL_CYCLES of that digit driven. Host writes land in a pending
//   buffer and are copied to the active buffer only at the frame boundary
//   (end of the last digit's SHOW), so a frame never mixes old/new data.
//
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     value[4*DIGITS-1:0] : hex nibbles, nibble i drives digit i
//     dots[DIGITS-1:0]    : decimal point per digit
//     digit_en[DIGITS-1:0]: 1 = digit lit in its slot, 0 = slot stays dark
//     load                : capture value/dots/digit_en into pending buffer
//     pending             : pending buffer holds data not yet applied
//     frame_start         : one-cycle pulse, aligned with the pins, on the
//                           first BLANK cycle of digit 0
//     segments[6:0]       : {g,f,e,d,c,b,a} pins, polarity SEG_ACTIVE_LOW
//     dp                  : decimal point pin, polarity SEG_ACTIVE_LOW
//     anodes[DIGITS-1:0]  : digit select pins, polarity AN_ACTIVE_LOW
//     dbg_state           : current scan FSM state (observation only)
// ---------------------------------------------------------------------------
module ssds_scan_controller
    import ssds_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int DWELL_CYCLES   = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dots,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic                  load,
    output logic                  pending,
    output logic                  frame_start,
    output logic [6:0]            segments,
    output logic                  dp,
    output logic [DIGITS-1:0]     anodes,
    output ssds_state_e           dbg_state
);

    localparam int TMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [0:0] S_BLANK = ST_BLANK;
    localparam logic [0:0] S_SHOW  = ST_SHOW;

    localparam logic SEG_AL = (SEG_ACTIVE_LOW != 0);
    localparam logic AN_AL  = (AN_ACTIVE_LOW != 0);

    localparam logic [DIGITS-1:0] AN_OFF = AN_AL ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    // Scan FSM
    logic [0:0]          r_state;
    logic [IW-1:0]       r_idx;
    logic [TW-1:0]       r_timer;

    // Double buffers
    logic [4*DIGITS-1:0] r_act_value;
    logic [DIGITS-1:0]   r_act_dots;
    logic [DIGITS-1:0]   r_act_en;
    logic [4*DIGITS-1:0] r_pend_value;
    logic [DIGITS-1:0]   r_pend_dots;
    logic [DIGITS-1:0]   r_pend_en;
    logic                r_pending;

    // Registered pins
    logic [6:0]          r_segments;
    logic                r_dp;
    logic [DIGITS-1:0]   r_anodes;
    logic                r_frame_start;

    logic                w_blank_done;
    logic                w_show_done;
    logic                w_last_idx;
    logic                w_frame_edge;
    logic                w_lit;
    logic [3:0]          w_nibble;
    logic [6:0]          w_seg_raw;
    logic [DIGITS-1:0]   w_onehot;

    assign w_blank_done = (r_state == S_BLANK) && (r_timer == TW'(BLANK_CYCLES - 1));
    assign w_show_done  = (r_state == S_SHOW)  && (r_timer == TW'(DWELL_CYCLES - 1));
    assign w_last_idx   = (r_idx == IW'(DIGITS - 1));
    assign w_frame_edge = w_show_done && w_last_idx;

    // A disabled digit keeps its slot timing but drives nothing at all,
    // so segments and dp stay dark too, not only its anode.
    assign w_lit    = (r_state == S_SHOW) && r_act_en[r_idx];
    assign w_nibble = r_act_value[{r_idx, 2'b00} +: 4];
    assign w_onehot = {{(DIGITS-1){1'b0}}, 1'b1} << r_idx;

    ssds_digit_mapper u_mapper (
        .i_nibble (w_nibble),
        .o_seg    (w_seg_raw)
    );

    // Scan sequencing: timer counts 0..N-1 inside a state and clears on
    // every transition; idx advances when leaving SHOW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_BLANK;
            r_idx   <= '0;
            r_timer <= '0;
        end else begin
            case (r_state)
                S_BLANK: begin
                    if (w_blank_done) begin
                        r_state <= S_SHOW;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_SHOW: begin
                    if (w_show_done) begin
                        r_state <= S_BLANK;
                        r_timer <= '0;
                        r_idx   <= w_last_idx ? '0 : r_idx + IW'(1);
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: begin
                    r_state <= S_BLANK;
                    r_timer <= '0;
                end
            endcase
        end
    end

    // Buffers. When load and the frame-boundary apply coincide, the apply
    // uses the old pending contents (non-blocking read) while the new
    // capture refills the pending buffer, so pending stays set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_value  <= '0;
            r_act_dots   <= '0;
            r_act_en     <= '0;
            r_pend_value <= '0;
            r_pend_dots  <= '0;
            r_pend_en    <= '0;
            r_pending    <= 1'b0;
        end else begin
            if (load) begin
                r_pend_value <= value;
                r_pend_dots  <= dots;
                r_pend_en    <= digit_en;
            end
            if (w_frame_edge && r_pending) begin
                r_act_value <= r_pend_value;
                r_act_dots  <= r_pend_dots;
                r_act_en    <= r_pend_en;
            end
            if (load) begin
                r_pending <= 1'b1;
            end else if (w_frame_edge) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Pin registers: computed from the current state/idx so every pin
    // (and frame_start) moves on the same edge, one cycle behind the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_segments    <= seg_off(SEG_AL);
            r_dp          <= pin_on(1'b0, SEG_AL);
            r_anodes      <= AN_OFF;
            r_frame_start <= 1'b0;
        end else begin
            r_segments    <= seg_on(w_lit ? w_seg_raw : SEG_BLANK, SEG_AL);
            r_dp          <= pin_on(w_lit & r_act_dots[r_idx], SEG_AL);
            r_anodes      <= w_lit ? (w_onehot ^ AN_OFF) : AN_OFF;
            r_frame_start <= (r_state == S_BLANK) && (r_idx == '0) && (r_timer == '0);
        end
    end

    assign segments    = r_segments;
    assign dp          = r_dp;
    assign anodes      = r_anodes;
    assign frame_start = r_frame_start;
    assign pending     = r_pending;
    assign dbg_state   = ssds_state_e'(r_state);

endmodule
